// File: rtl/riscv_fetch_pkg.sv
// -----------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared types and constants for the instruction fetch unit:
//   fetch_state_t    - fetch FSM states
//   fault_cause_t    - encoding presented on fault_cause
//   NOP_INSTR        - instruction register value after reset (addi x0,x0,0)
//   DEFAULT_RESET_PC - default PC loaded on reset
//   is_misaligned()  - word-alignment test on the two address LSBs
// -----------------------------------------------------------------------------
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_FAULT = 2'd3
    } fetch_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'b00,
        CAUSE_BUS_ERR  = 2'b01,
        CAUSE_MISALIGN = 2'b10
    } fault_cause_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and memory.
//   imem_req_valid  fetch -> mem  request valid
//   imem_req_ready  mem -> fetch  memory accepts the request this cycle
//   imem_addr       fetch -> mem  fetch address
//   imem_rsp_valid  mem -> fetch  response valid
//   imem_rsp_data   mem -> fetch  instruction word
//   imem_rsp_err    mem -> fetch  bus error qualifying imem_rsp_valid
// master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;
    logic            imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );
endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// -----------------------------------------------------------------------------
// fetch_pc_reg
// Program counter register with +4 adder, branch/jump target mux and target
// alignment check.
//   clk, reset   clock, synchronous active-high reset (pc <= RESET_PC)
//   accept       held instruction is consumed this cycle
//   pc_src       take pc_target instead of pc + 4
//   pc_target    branch/jump target
//   pc           current PC (address of the held instruction)
//   pc_plus4     pc + 4, wrapping modulo 2^XLEN
//   misaligned   pc_src is set and pc_target is not word aligned
// -----------------------------------------------------------------------------
module fetch_pc_reg
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            accept,
    input  logic            pc_src,
    input  logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misaligned
);

    assign pc_plus4   = pc + XLEN'(4);
    assign misaligned = pc_src && is_misaligned(pc_target[1:0]);

    // A misaligned target leaves pc pointing at the faulting instruction.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            pc <= RESET_PC;
        end else if (accept && !misaligned) begin
            pc <= pc_src ? pc_target : pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage upstream of the main decoder. Issues one request at a time on
// the imem bus, latches the returned word, holds it for the decoder until
// accepted, then advances to pc + 4 or the supplied branch/jump target.
//   clk, reset        clock, synchronous active-high reset
//   imem              instruction memory bus (master side)
//   pc_src, pc_target next-PC select and target, sampled on accept
//   instr_valid       instr/op/pc/pc_plus4 valid for the decoder
//   instr_ready       decoder/datapath consumes the held instruction
//   instr, op         instruction register and its opcode field
//   pc, pc_plus4      address of the held instruction and its link value
//   fetch_fault       sticky fault flag (terminal until reset)
//   fault_cause       00 none, 01 bus error, 10 misaligned target
//   instr_count       accepted instructions, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    input  logic                pc_src,
    input  logic [XLEN-1:0]     pc_target,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [31:0]         instr,
    output logic [6:0]          op,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     pc_plus4,
    output logic                fetch_fault,
    output logic [1:0]          fault_cause,
    output logic [CNT_W-1:0]    instr_count
);

    fetch_state_t state;
    fault_cause_t cause_q;
    logic         req_valid_q;
    logic         instr_valid_q;
    logic         accept;
    logic         misaligned;

    // Only a consume in S_HOLD counts; instr_ready elsewhere is ignored.
    assign accept = (state == S_HOLD) && instr_ready;

    fetch_pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept),
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_addr      = pc;
    assign instr_valid         = instr_valid_q;
    assign op                  = instr[6:0];
    assign fault_cause         = cause_q;

    // Handshake outputs are registered alongside the state, so they are low
    // throughout reset and there is no combinational path from instr_ready
    // to imem_req_valid. After reset the request rises one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_REQ;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            // NOTE: the instruction register is a plain register, not a
            // memory array, so resetting it to a NOP is cheap and keeps the
            // decoder input defined from the first cycle.
            instr         <= NOP_INSTR;
            instr_count   <= '0;
            fetch_fault   <= 1'b0;
            cause_q       <= CAUSE_NONE;
        end else begin
            // NOTE: every branch either assigns or intentionally holds a flop;
            // in an always_ff a missing assignment is storage, not a latch.
            case (state)
                S_REQ: begin
                    if (req_valid_q && imem.imem_req_ready) begin
                        state       <= S_WAIT;
                        req_valid_q <= 1'b0;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rsp_valid) begin
                        if (imem.imem_rsp_err) begin
                            state       <= S_FAULT;
                            fetch_fault <= 1'b1;
                            cause_q     <= CAUSE_BUS_ERR;
                        end else begin
                            state         <= S_HOLD;
                            instr         <= imem.imem_rsp_data;
                            instr_valid_q <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        instr_count   <= instr_count + CNT_W'(1);
                        instr_valid_q <= 1'b0;
                        if (misaligned) begin
                            state       <= S_FAULT;
                            fetch_fault <= 1'b1;
                            cause_q     <= CAUSE_MISALIGN;
                        end else begin
                            state       <= S_REQ;
                            req_valid_q <= 1'b1;
                        end
                    end
                end
                S_FAULT: begin
                    // Terminal until reset; instr and pc keep debug values.
                    req_valid_q   <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state <= S_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
// Directed bench for instr_fetch_unit. Expected fetch addresses and expected
// held instructions are pushed to queues when stimulus is driven and popped
// when the DUT presents a request or a valid instruction. All driving and
// sampling happens on the falling clock edge. CNT_W = 4 so counter wrap is
// reachable in a few fetches.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;
    import riscv_fetch_pkg::*;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_instr_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             pc_src = 1'b0;
    logic [XLEN-1:0]  pc_target = '0;
    logic             instr_valid;
    logic             instr_ready = 1'b0;
    logic [31:0]      instr;
    logic [6:0]       op;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_plus4;
    logic             fetch_fault;
    logic [1:0]       fault_cause;
    logic [CNT_W-1:0] instr_count;

    instr_fetch_unit_if #(.XLEN(XLEN)) imem ();

    instr_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (32'h0000_0000),
        .CNT_W    (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .pc_src      (pc_src),
        .pc_target   (pc_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .op          (op),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .fetch_fault (fetch_fault),
        .fault_cause (fault_cause),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    exp_instr_t  sb_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] exp_pc;
    logic [3:0]  exp_count;
    logic [31:0] last_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model state reset; the first request after reset must target RESET_PC.
    task automatic do_reset(input int cycles);
        reset                   = 1'b1;
        instr_ready             = 1'b0;
        pc_src                  = 1'b0;
        imem.imem_rsp_valid     = 1'b0;
        imem.imem_rsp_err       = 1'b0;
        sb_q.delete();
        addr_q.delete();
        exp_pc    = 32'h0;
        exp_count = 4'd0;
        addr_q.push_back(32'h0);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("rst_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
            chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        end
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_count", {28'b0, instr_count}, 32'd0);
        chk("rst_fault", {30'b0, fault_cause}, 32'd0);
        reset = 1'b0;
    endtask

    // Wait for a request, compare its address, stall `stall` cycles, accept.
    task automatic req_phase(input int stall);
        bit          seen;
        logic [31:0] exp_addr;
        seen = imem.imem_req_valid;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = imem.imem_req_valid;
        end
        chk("req_seen", {31'b0, seen}, 32'd1);
        exp_addr = 32'hxxxx_xxxx;
        if (addr_q.size() > 0) exp_addr = addr_q.pop_front();
        chk("req_addr", imem.imem_addr, exp_addr);
        chk("req_count", {28'b0, instr_count}, {28'b0, exp_count});
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'b0, imem.imem_req_valid}, 32'd1);
            chk("stall_addr", imem.imem_addr, exp_addr);
        end
        imem.imem_req_ready = 1'b1;
        @(negedge clk);
        imem.imem_req_ready = 1'b0;
        chk("req_drop", {31'b0, imem.imem_req_valid}, 32'd0);
    endtask

    // Return a response `lat` cycles after acceptance, then compare the held
    // instruction against the scoreboard.
    task automatic rsp_phase(input logic [31:0] data, input int lat, input logic err);
        exp_instr_t e;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            chk("wait_instr_valid", {31'b0, instr_valid}, 32'd0);
        end
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = data;
        imem.imem_rsp_err   = err;
        if (!err) sb_q.push_back('{pc: exp_pc, instr: data});
        @(negedge clk);
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_err   = 1'b0;
        if (err) begin
            chk("buserr_fault", {31'b0, fetch_fault}, 32'd1);
            chk("buserr_cause", {30'b0, fault_cause}, {30'b0, CAUSE_BUS_ERR});
            chk("buserr_instr_valid", {31'b0, instr_valid}, 32'd0);
        end else begin
            chk("hold_valid", {31'b0, instr_valid}, 32'd1);
            e = '{pc: 32'hxxxx_xxxx, instr: 32'hxxxx_xxxx};
            if (sb_q.size() > 0) e = sb_q.pop_front();
            chk("hold_instr", instr, e.instr);
            chk("hold_op", {25'b0, op}, {25'b0, e.instr[6:0]});
            chk("hold_pc", pc, e.pc);
            chk("hold_pc_plus4", pc_plus4, e.pc + 32'd4);
            last_instr = e.instr;
        end
    endtask

    // Consume the held instruction with the given next-PC selection.
    task automatic accept(input logic src, input logic [31:0] tgt);
        bit bad;
        instr_ready = 1'b1;
        pc_src      = src;
        pc_target   = tgt;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_src      = 1'b0;
        pc_target   = 32'h0;
        exp_count   = exp_count + 4'd1;
        bad         = src && (tgt[1:0] != 2'b00);
        chk("acc_count", {28'b0, instr_count}, {28'b0, exp_count});
        chk("acc_instr_valid", {31'b0, instr_valid}, 32'd0);
        if (bad) begin
            chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
            chk("mis_cause", {30'b0, fault_cause}, {30'b0, CAUSE_MISALIGN});
            chk("mis_pc", pc, exp_pc);
        end else begin
            exp_pc = src ? tgt : exp_pc + 32'd4;
            addr_q.push_back(exp_pc);
        end
    endtask

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "time limit expired");
    end

    initial begin
        imem.imem_req_ready = 1'b1;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;
        imem.imem_rsp_err   = 1'b0;

        // Reset with req_ready high, then the first request appears one
        // cycle after release and is accepted immediately.
        do_reset(3);
        @(negedge clk);
        chk("first_req_valid", {31'b0, imem.imem_req_valid}, 32'd1);
        chk("first_req_addr", imem.imem_addr, addr_q.pop_front());
        chk("first_instr_valid", {31'b0, instr_valid}, 32'd0);
        @(negedge clk);
        imem.imem_req_ready = 1'b0;
        chk("first_req_drop", {31'b0, imem.imem_req_valid}, 32'd0);

        // Sequential fetch with 2-cycle response latency.
        rsp_phase(32'h0050_0093, 2, 1'b0);
        accept(1'b0, 32'h0);
        req_phase(0);

        // Branch taken to 0x40, then sequential to 0x44.
        rsp_phase(32'h00a0_0113, 1, 1'b0);
        accept(1'b1, 32'h0000_0040);
        req_phase(0);
        rsp_phase(32'h0000_0063, 3, 1'b0);
        accept(1'b0, 32'h0);

        // Memory stall on the request, then decoder backpressure with a
        // spurious response in the middle.
        req_phase(3);
        rsp_phase(32'h0040_006f, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = 32'hdead_beef;
            end
            @(negedge clk);
            imem.imem_rsp_valid = 1'b0;
            chk("bp_instr", instr, last_instr);
            chk("bp_pc", pc, 32'h0000_0044);
            chk("bp_req_valid", {31'b0, imem.imem_req_valid}, 32'd0);
            chk("bp_instr_valid", {31'b0, instr_valid}, 32'd1);
        end
        accept(1'b0, 32'h0);

        // Misaligned branch target at pc 0x48.
        req_phase(0);
        rsp_phase(32'h0000_0013, 1, 1'b0);
        accept(1'b1, 32'h0000_0042);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mis_idle_req", {31'b0, imem.imem_req_valid}, 32'd0);
            chk("mis_idle_pc", pc, 32'h0000_0048);
        end

        // Bus error on the response.
        do_reset(2);
        req_phase(0);
        rsp_phase(32'hffff_ffff, 2, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("err_idle_req", {31'b0, imem.imem_req_valid}, 32'd0);
            chk("err_sticky", {31'b0, fetch_fault}, 32'd1);
        end

        // Reset during S_WAIT; stale responses right after release are dropped.
        do_reset(2);
        req_phase(0);
        do_reset(2);
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        imem.imem_rsp_valid = 1'b0;
        chk("stale_instr", instr, NOP_INSTR);
        chk("stale_pc", pc, 32'h0);
        chk("stale_instr_valid", {31'b0, instr_valid}, 32'd0);

        // Sixteen accepts: counter reaches 15 then wraps to 0.
        for (int i = 0; i < 16; i++) begin
            req_phase(0);
            rsp_phase(32'h0000_0013 | (i << 7), 1, 1'b0);
            accept(1'b0, 32'h0);
        end
        chk("count_wrap", {28'b0, instr_count}, 32'd0);

        // PC wrap: jump to the last word, sequential fetch returns to 0.
        req_phase(0);
        rsp_phase(32'h0000_006f, 1, 1'b0);
        accept(1'b1, 32'hffff_fffc);
        req_phase(0);
        rsp_phase(32'h0000_0013, 1, 1'b0);
        accept(1'b0, 32'h0);
        req_phase(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the main decoder. It owns the PC register and issues valid/ready requests to the instruction memory.
- It latches the returned word into an instruction register and presents op = instr[6:0] to the decoder, holding it until the downstream datapath accepts it.
- The next PC is PC+4, or the branch/jump target supplied by the datapath when the instruction is accepted.
- It also counts retired fetches and flags memory errors and misaligned targets.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  response data valid.
- imem_rsp_data  in  32  instruction word.
- imem_rsp_err  in  1  bus error qualifying imem_rsp_valid.
- pc_src  in  1  take pc_target (Branch&Zero | Jump), sampled on accept.
- pc_target  in  XLEN  branch/jump target, sampled on accept.
- instr_valid  out  1  instr/op/pc valid for the decoder.
- instr_ready  in  1  downstream consumes the held instruction.
- instr  out  32  instruction register.
- op  out  7  instr[6:0], feeds the main decoder.
- pc  out  XLEN  address of the held instruction.
- pc_plus4  out  XLEN  pc + 4, used for the JAL link value.
- fetch_fault  out  1  sticky fault flag.
- fault_cause  out  2  00 none, 01 bus error, 10 misaligned target.
- instr_count  out  CNT_W  number of accepted instructions.

Behaviour:
- Reset (synchronous, active-high, clk only):
  - state = S_REQ, pc = RESET_PC, instr = 32'h0000_0013 (addi x0,x0,0, op = 0010011).
  - instr_count = 0, fetch_fault = 0, fault_cause = 00.
  - While reset is high: imem_req_valid = 0 and instr_valid = 0.
  - Reset wins over every other event in the same cycle.
- State S_REQ:
  - imem_req_valid = 1, imem_addr = pc.
  - Address and valid stay stable until imem_req_ready.
  - On req_valid & req_ready, go to S_WAIT.
- State S_WAIT:
  - imem_req_valid = 0.
  - On rsp_valid & !rsp_err: instr <= rsp_data, go to S_HOLD.
  - On rsp_valid & rsp_err: fetch_fault <= 1, fault_cause <= 01, go to S_FAULT.
  - Response latency is unbounded; there is no timeout.
- State S_HOLD:
  - instr_valid = 1; instr, op, pc and pc_plus4 are stable.
  - On instr_ready, with pc_src/pc_target sampled in the same cycle:
    - pc <= pc_src ? pc_target : pc + 4.
    - instr_count <= instr_count + 1, wrapping modulo 2^CNT_W.
    - Go to S_REQ.
  - If pc_src = 1 and pc_target[1:0] != 00 at accept:
    - instr_count still increments; pc is not updated.
    - fetch_fault <= 1, fault_cause <= 10, go to S_FAULT.
- State S_FAULT:
  - Terminal until reset.
  - imem_req_valid = 0, instr_valid = 0.
  - instr and pc keep the last values for debug.
- imem_rsp_valid outside S_WAIT (including stale responses after reset) is ignored.
- At most one outstanding request; a response can arrive no earlier than the cycle after acceptance.
- Throughput: at least 3 cycles per instruction (request accept, response, consume).
- instr_ready outside S_HOLD has no effect.
- pc + 4 wraps modulo 2^XLEN; 0xFFFF_FFFC becomes 0x0000_0000.
- All outputs are decoded from registered state; there is no combinational path from instr_ready to imem_req_valid.

Decomposition:
- Shared package riscv_fetch_pkg contains:
  - state enum {S_REQ, S_WAIT, S_HOLD, S_FAULT};
  - NOP_INSTR = 32'h0000_0013;
  - fault_cause encodings;
  - RESET_PC default.
- One sub-module: fetch_pc_reg (PC register, +4 adder, target mux and alignment check). The FSM and counter stay in the top.

Test Plan:
- Reset, then release with imem_req_ready = 1 -> the next cycle shows imem_req_valid = 1 and imem_addr = 0x0, with instr_valid = 0 throughout reset.
- Sequential fetch: rsp_data 0x00500093 after a 2-cycle latency, instr_ready = 1 -> op = 0010011, pc = 0x0, pc_plus4 = 0x4; the next request has addr = 0x4 and instr_count = 1.
- Branch taken: at accept, pc_src = 1 and pc_target = 0x40 -> next imem_addr = 0x40. A repeat with pc_src = 0 at pc 0x40 -> next addr = 0x44.
- Backpressure: instr_ready low for 5 cycles in S_HOLD -> instr and pc stable, imem_req_valid = 0, and a spurious rsp_valid is ignored. Memory stall with req_ready low for 3 cycles -> addr stable.
- Faults:
  - rsp_err = 1 -> fetch_fault = 1, fault_cause = 01, no further requests.
  - pc_src = 1 with target 0x42 -> fault_cause = 10, pc unchanged, instr_count incremented.
- Reset asserted mid-S_WAIT, with a stale rsp_valid arriving the cycle after release -> pc = 0 and the stale response is dropped. With CNT_W = 4 forced to 15, a further accept -> instr_count = 0.
